// File: rtl/mem_access_stage.sv
// Memory stage of the five-stage RISC-V pipeline.
// Holds the Execute->Memory and Memory->Writeback registers and sequences each
// load/store through a variable-latency req/ack data-memory handshake, stalling
// upstream and injecting writeback bubbles while an access is outstanding.
`timescale 1ns/1ps
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic [4:0]        RD_E,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [DATA_W-1:0] PCPlus4E,
  output logic              stallM,
  output logic              RegWriteM,
  output logic [4:0]        RD_M,
  output logic [DATA_W-1:0] ALUResultM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              RegWriteW,
  output logic [4:0]        RD_W,
  output logic [DATA_W-1:0] ResultW,
  output logic              timeout_err
);

  // Counter must hold TIMEOUT-1; keep at least 4 bits.
  localparam int CNT_W = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Writeback source select: 01 memory, 10 PC+4, 00/11 ALU.
  function automatic logic [DATA_W-1:0] wb_select(
    input logic [1:0]        src,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem,
    input logic [DATA_W-1:0] pc4
  );
    logic [DATA_W-1:0] r;
    case (src)
      2'b01:   r = mem;
      2'b10:   r = pc4;
      default: r = alu;
    endcase
    return r;
  endfunction

  logic              mem_write_m;
  logic [1:0]        result_src_m;
  logic [DATA_W-1:0] write_data_m;
  logic [DATA_W-1:0] pc_plus4_m;

  logic [0:0]        state;
  logic [CNT_W-1:0]  wait_cnt;

  logic              memop_m;
  logic              timeout_hit;
  logic              access_done;
  logic [DATA_W-1:0] load_data;

  // Stores, and loads (writeback from memory without a store), use the memory port.
  assign memop_m     = mem_write_m | (result_src_m == 2'b01);
  // Timeout only fires in WAIT on the last allowed cycle; an ack there wins.
  assign timeout_hit = (state == ST_WAIT) && !dmem_ack && (wait_cnt == CNT_LAST);
  assign access_done = dmem_ack | timeout_hit;
  assign stallM      = memop_m & ~access_done;
  assign load_data   = timeout_hit ? '0 : dmem_rdata;

  assign dmem_req    = memop_m;
  assign dmem_we     = mem_write_m;
  assign dmem_addr   = ALUResultM;
  assign dmem_wdata  = write_data_m;

  // E->M register: capture on every non-stalled edge, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteM    <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      RD_M         <= 5'd0;
      ALUResultM   <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
    end else if (!stallM) begin
      RegWriteM    <= RegWriteE;
      mem_write_m  <= MemWriteE;
      result_src_m <= ResultSrcE;
      RD_M         <= RD_E;
      ALUResultM   <= ALUResultE;
      write_data_m <= WriteDataE;
      pc_plus4_m   <= PCPlus4E;
    end
  end

  // Access sequencer: IDLE is the first request cycle, WAIT counts further cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else if (memop_m) begin
      if (state == ST_IDLE) begin
        if (!dmem_ack) begin
          state    <= ST_WAIT;
          wait_cnt <= CNT_ONE;
        end
      end else begin
        if (access_done) begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + CNT_ONE;
        end
      end
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (memop_m && timeout_hit) begin
      timeout_err <= 1'b1;
    end
  end

  // M->W register: result on completion, bubble on every stalled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      RD_W      <= 5'd0;
      ResultW   <= '0;
    end else if (stallM) begin
      RegWriteW <= 1'b0;
      RD_W      <= 5'd0;
      ResultW   <= '0;
    end else begin
      RegWriteW <= RegWriteM;
      RD_W      <= RD_M;
      ResultW   <= wb_select(result_src_m, ALUResultM, load_data, pc_plus4_m);
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random instruction streams,
// checked cycle by cycle against a per-instruction latency/writeback model.
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [4:0]  RD_E;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic        stallM, RegWriteM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        RegWriteW;
  logic [4:0]  RD_W;
  logic [31:0] ResultW;
  logic        timeout_err;

  mem_access_stage #(.TIMEOUT(TO), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .RD_E(RD_E),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .stallM(stallM), .RegWriteM(RegWriteM), .RD_M(RD_M), .ALUResultM(ALUResultM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .RegWriteW(RegWriteW), .RD_W(RD_W), .ResultW(ResultW), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // d = number of request cycles without ack before the ack arrives.
  typedef struct packed {
    logic        rw;
    logic        mw;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic [7:0]  d;
  } instr_t;

  instr_t      prog[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        e_rw_w;
  logic [4:0]  e_rd_w;
  logic [31:0] e_res_w;
  logic        e_te;

  function automatic instr_t mk(input logic rw, input logic mw, input logic [1:0] src,
                                input logic [4:0] rd, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [31:0] pc4,
                                input logic [31:0] rdata, input int d);
    instr_t t;
    t.rw = rw; t.mw = mw; t.src = src; t.rd = rd; t.alu = alu;
    t.wd = wd; t.pc4 = pc4; t.rdata = rdata; t.d = 8'(d);
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.rw    = 1'($urandom);
    t.mw    = ($urandom_range(0, 3) == 0);
    t.src   = 2'($urandom);
    t.rd    = 5'($urandom);
    t.alu   = $urandom;
    t.wd    = $urandom;
    t.pc4   = $urandom;
    t.rdata = $urandom;
    t.d     = 8'($urandom_range(0, 5));
    return t;
  endfunction

  function automatic bit is_memop(input instr_t t);
    return t.mw || (t.src == 2'b01);
  endfunction

  function automatic logic [31:0] wb_value(input instr_t t, input bit timed_out);
    case (t.src)
      2'b10:   return t.pc4;
      2'b01:   return timed_out ? 32'd0 : t.rdata;
      default: return t.alu;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_e(input instr_t e);
    RegWriteE  = e.rw;
    MemWriteE  = e.mw;
    ResultSrcE = e.src;
    RD_E       = e.rd;
    ALUResultE = e.alu;
    WriteDataE = e.wd;
    PCPlus4E   = e.pc4;
  endtask

  // One clock: drive E and memory response, check at negedge, advance past the edge.
  task automatic cycle(input instr_t e, input instr_t m, input logic ack,
                       input logic [31:0] rdata, input bit exp_stall);
    drive_e(e);
    dmem_ack   = ack;
    dmem_rdata = rdata;
    @(negedge clk);
    chk("stallM",      32'(stallM),    32'(exp_stall));
    chk("dmem_req",    32'(dmem_req),  32'(is_memop(m)));
    chk("dmem_we",     32'(dmem_we),   32'(m.mw));
    chk("dmem_addr",   dmem_addr,      m.alu);
    chk("dmem_wdata",  dmem_wdata,     m.wd);
    chk("RegWriteM",   32'(RegWriteM), 32'(m.rw));
    chk("RD_M",        32'(RD_M),      32'(m.rd));
    chk("ALUResultM",  ALUResultM,     m.alu);
    chk("RegWriteW",   32'(RegWriteW), 32'(e_rw_w));
    chk("RD_W",        32'(RD_W),      32'(e_rd_w));
    chk("ResultW",     ResultW,        e_res_w);
    chk("timeout_err", 32'(timeout_err), 32'(e_te));
    @(posedge clk);
    #1;
  endtask

  // Runs the queued program; entered just after an edge with M holding a nop.
  task automatic run_prog();
    instr_t nop_i, nxt, first;
    int     len;
    bit     to;
    logic   ack;
    nop_i = '0;
    first = (prog.size() > 0) ? prog[0] : nop_i;
    cycle(first, nop_i, 1'($urandom), $urandom, 1'b0);
    e_rw_w = 1'b0; e_rd_w = 5'd0; e_res_w = 32'd0;
    for (int k = 0; k < prog.size(); k++) begin
      nxt = (k + 1 < prog.size()) ? prog[k+1] : nop_i;
      if (is_memop(prog[k])) begin
        to  = (int'(prog[k].d) >= TO);
        len = to ? TO : int'(prog[k].d) + 1;
      end else begin
        to  = 1'b0;
        len = 1;
      end
      for (int j = 0; j < len; j++) begin
        if (is_memop(prog[k])) begin
          ack = (j == int'(prog[k].d));
          cycle(nxt, prog[k], ack, ack ? prog[k].rdata : $urandom, j < len - 1);
        end else begin
          cycle(nxt, prog[k], 1'($urandom), $urandom, 1'b0);
        end
        if (j < len - 1) begin
          e_rw_w = 1'b0; e_rd_w = 5'd0; e_res_w = 32'd0;
        end else begin
          e_rw_w = prog[k].rw; e_rd_w = prog[k].rd; e_res_w = wb_value(prog[k], to);
          if (to) e_te = 1'b1;
        end
      end
    end
    cycle(nop_i, nop_i, 1'($urandom), $urandom, 1'b0);
    e_rw_w = 1'b0; e_rd_w = 5'd0; e_res_w = 32'd0;
    prog.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    drive_e(rand_instr());
    dmem_ack   = 1'($urandom);
    dmem_rdata = $urandom;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stallM",      32'(stallM),      32'd0);
    chk("rst_RegWriteM",   32'(RegWriteM),   32'd0);
    chk("rst_RD_M",        32'(RD_M),        32'd0);
    chk("rst_ALUResultM",  ALUResultM,       32'd0);
    chk("rst_dmem_req",    32'(dmem_req),    32'd0);
    chk("rst_dmem_we",     32'(dmem_we),     32'd0);
    chk("rst_RegWriteW",   32'(RegWriteW),   32'd0);
    chk("rst_RD_W",        32'(RD_W),        32'd0);
    chk("rst_ResultW",     ResultW,          32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    drive_e('0);
    @(posedge clk);
    #1;
    e_rw_w = 1'b0; e_rd_w = 5'd0; e_res_w = 32'd0; e_te = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive_e('0);
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    e_rw_w = 1'b0; e_rd_w = 5'd0; e_res_w = 32'd0; e_te = 1'b0;

    // Reset with random inputs held for two cycles.
    do_reset(2);

    // ALU op, zero-wait load, 3-cycle load (ack in last timeout cycle), back-to-back store.
    prog.push_back(mk(1'b1, 1'b0, 2'b00, 5'd5,  32'h10,  32'h0,        32'h4,    32'h0,        0));
    prog.push_back(mk(1'b1, 1'b0, 2'b01, 5'd6,  32'h100, 32'h0,        32'h8,    32'hDEADBEEF, 0));
    prog.push_back(mk(1'b1, 1'b0, 2'b01, 5'd8,  32'h200, 32'h0,        32'hC,    32'h12345678, 3));
    prog.push_back(mk(1'b0, 1'b1, 2'b00, 5'd0,  32'h104, 32'hCAFEF00D, 32'h10,   32'h0,        0));
    prog.push_back(mk(1'b1, 1'b0, 2'b11, 5'd12, 32'h55,  32'h0,        32'h14,   32'h0,        0));
    run_prog();

    // Load with no ack: timeout, zero data written, sticky error.
    prog.push_back(mk(1'b1, 1'b0, 2'b01, 5'd9,  32'h300, 32'h0,        32'h18,   32'hFFFFFFFF, 9));
    prog.push_back(mk(1'b1, 1'b0, 2'b00, 5'd10, 32'h77,  32'h0,        32'h1C,   32'h0,        0));
    run_prog();

    // Reset while an access is waiting.
    drive_e(mk(1'b1, 1'b0, 2'b01, 5'd7, 32'h400, 32'h0, 32'h20, 32'h0, 0));
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    drive_e('0);
    @(negedge clk);
    chk("wait_stallM",   32'(stallM),   32'd1);
    chk("wait_dmem_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_dmem_req",    32'(dmem_req),    32'd0);
    chk("midrst_stallM",      32'(stallM),      32'd0);
    chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
    chk("midrst_RegWriteW",   32'(RegWriteW),   32'd0);
    @(posedge clk); #1;
    e_rw_w = 1'b0; e_rd_w = 5'd0; e_res_w = 32'd0; e_te = 1'b0;

    // PC+4 writeback after the abandoned access.
    prog.push_back(mk(1'b1, 1'b0, 2'b10, 5'd3, 32'h999, 32'h0, 32'h1004, 32'h0, 0));
    run_prog();

    // Random instruction streams, each from a fresh reset.
    for (int ep = 0; ep < 3; ep++) begin
      do_reset(2);
      for (int i = 0; i < 25; i++) prog.push_back(rand_instr());
      run_prog();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the five-stage RISC-V pipeline. It holds the Execute→Memory and Memory→Writeback pipeline registers and runs each load or store through a variable-latency data-memory req/ack handshake. It stalls upstream stages while an access is outstanding and inserts a writeback bubble during each stall cycle. Its M- and W-stage destination/write-enable/result outputs are the inputs the forwarding hazard unit compares against Rs1_E/Rs2_E.

## Interface
- TIMEOUT, 16: maximum request cycles per access without ack; legal range ≥2.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- RegWriteE  in  1  register write enable from Execute.
- MemWriteE  in  1  store enable from Execute.
- ResultSrcE  in  2  writeback select: 00 = ALU, 01 = memory, 10 = PC+4, 11 = ALU.
- RD_E  in  5  destination register from Execute.
- ALUResultE  in  32  ALU result; also the memory address.
- WriteDataE  in  32  store data, already forwarded.
- PCPlus4E  in  32  PC+4 of the instruction.
- stallM  out  1  freeze Fetch/Decode/Execute; combinational.
- RegWriteM  out  1  M-stage write enable.
- RD_M  out  5  M-stage destination register.
- ALUResultM  out  32  M-stage ALU result, used as the forwarding value.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  equals ALUResultM, word access; bits [1:0] pass through unmodified.
- dmem_wdata  out  32  equals WriteDataM.
- dmem_rdata  in  32  load data; sampled only when dmem_req && dmem_ack.
- dmem_ack  in  1  access complete; ignored when dmem_req = 0.
- RegWriteW  out  1  W-stage write enable.
- RD_W  out  5  W-stage destination register.
- ResultW  out  32  writeback value.
- timeout_err  out  1  sticky: set when an access times out; cleared only by rst.

## Operation
- M register: captures all E inputs on each edge where stallM = 0. Holds its contents while stallM = 1. Upstream stages must hold their E outputs stable while stallM = 1.
- Memory op in M:
  - store when MemWriteM = 1.
  - load when ResultSrcM = 01 and MemWriteM = 0.
  - Only these two cases raise dmem_req. dmem_req = memop_M (combinational from the M register and FSM state).
- FSM states: IDLE, WAIT; 4-bit-or-wider counter wait_cnt.
  - IDLE: the first request cycle of an access. wait_cnt = 0.
    - memop_M and ack: complete, stay in IDLE.
    - memop_M and no ack: go to WAIT, wait_cnt ← 1.
  - WAIT:
    - ack: complete, go to IDLE.
    - No ack and wait_cnt = TIMEOUT−1: timeout completion. Set timeout_err, load data is forced to 0, go to IDLE.
    - Otherwise: wait_cnt + 1.
- stallM = memop_M && !complete. complete = ack, or timeout in WAIT.
- Non-memory instructions complete in the cycle they are in M. They never stall.
- W register: on each non-stalled edge it captures:
  - RegWriteW ← RegWriteM, RD_W ← RD_M.
  - ResultW ← mux(ResultSrcM): ALUResultM, load data, or PCPlus4M.
- On a stalled edge the W register loads a bubble: RegWriteW ← 0, RD_W ← 0, ResultW ← 0.
- Back-to-back memory ops: dmem_req stays high continuously. The address and data change on the edge after completion, and the FSM re-enters IDLE for the new access.
- Stores write back only if RegWriteM = 1. A store with RegWriteM = 1 is legal but unusual and is passed through as-is.

## Timing
- Reset: on an rst edge, all M and W registers, the FSM, and timeout_err clear.
  - Values after reset: RegWriteM = 0, RD_M = 0, ALUResultM = 0, RegWriteW = 0, RD_W = 0, ResultW = 0, dmem_req = 0, dmem_we = 0, stallM = 0, timeout_err = 0, state IDLE.
- Latency: the instruction is in M one cycle after E. With zero-wait ack it reaches W one cycle after that. Each cycle without ack adds one stall cycle and one W bubble.
- Maximum stall is TIMEOUT−1 cycles per access. Request signals stay stable for the whole access.
- Reset mid-access: dmem_req is 0 from the cycle after the rst edge. The pending access is abandoned and no W write occurs for it.
- ack in the final timeout cycle counts as a normal completion. timeout_err is not set.

## Test plan
- Reset: assert rst for 2 cycles with random inputs → every output is 0 in the cycle after reset is released.
- ALU op: RegWriteE = 1, RD_E = 5, ALUResultE = 0x10, ResultSrcE = 00.
  - Next cycle: RegWriteM = 1, RD_M = 5, ALUResultM = 0x10, dmem_req = 0.
  - Following cycle: RegWriteW = 1, RD_W = 5, ResultW = 0x10.
- Zero-wait load: address 0x100, ack in the same cycle with rdata 0xDEADBEEF → stallM never 1; ResultW = 0xDEADBEEF and RD_W valid one cycle later.
- Load with ack after 3 cycles:
  - stallM = 1 for 3 cycles; RD_M and dmem_addr are stable.
  - RegWriteW = 0 for those 3 cycles.
  - Then ResultW = rdata. Follow with a back-to-back store at 0x104: dmem_req stays high and dmem_we = 1.
- Timeout, TIMEOUT = 4, no ack:
  - dmem_req is high for 4 cycles and stallM for 3.
  - timeout_err = 1 and remains 1 afterwards; ResultW = 0 with RegWriteW = 1.
- Reset during WAIT → dmem_req = 0, stallM = 0, timeout_err = 0 the cycle after the rst edge. A PC+4 op (ResultSrcE = 10) afterwards gives ResultW = PCPlus4E.
